ysyx_22041071_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_22041071_ifu_fetch

Overview:
Instruction-fetch bus stage directly downstream of the PC generator. It accepts one fetch address per handshake and issues a single-beat AXI read (AR channel). It captures the R beat and extracts the 32-bit instruction from the 64-bit data word. It presents {pc, inst} to decode through a valid/ready register and supports pipeline redirect (flush) while a transaction is outstanding.

Parameters:
ADDR_W, 64, fetch address width
DATA_W, 64, AXI read data width
LEN_W, 8, AXI arlen width
ID_W, 4, AXI id width
FETCH_ID, 0, constant arid used for all fetches

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc_valid  in  1  fetch request from PC stage
pc_ready  out  1  stage can accept a request
pc_addr  in  ADDR_W  fetch address (4-byte aligned)
flush  in  1  redirect: abandon current fetch/result
ar_valid  out  1  AXI read address valid
ar_ready  in  1  AXI read address ready
ar_addr  out  ADDR_W  AXI address (= pc_addr, 8-byte aligned: bits[2:0]=0)
ar_id  out  ID_W  = FETCH_ID
ar_len  out  LEN_W  always 0
ar_size  out  3  always 3'b011 (8 bytes)
ar_burst  out  2  always 2'b01
r_valid  in  1  AXI read data valid
r_ready  out  1  AXI read data ready
r_data  in  DATA_W  read data
r_resp  in  2  read response
r_last  in  1  last beat (expected 1)
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_pc  out  ADDR_W  PC of instruction
inst  out  32  instruction word
inst_err  out  1  bus error on this fetch (r_resp != 0)

Behaviour:
- Reset: state=IDLE; ar_valid=0, r_ready=0, inst_valid=0, inst_err=0, inst=0, inst_pc=0, ar_addr=0, drop=0. Reset mid-transaction abandons it silently; no bus response is awaited after reset.
- States: IDLE, AR, R, HOLD.
- IDLE: pc_ready=1. If pc_valid & !flush: latch pc_addr into pc_q, set ar_addr = {pc_addr[ADDR_W-1:3],3'b0}, ar_valid=1 next cycle, go to AR. If pc_valid & flush: ignore the request.
- AR: ar_valid held high and ar_addr stable until ar_ready (AXI rule: never retract). On ar_valid&ar_ready: ar_valid=0, go to R. A flush in AR sets drop=1; the AR still completes.
- R: r_ready=1. On r_valid: if drop|flush, discard the beat, clear drop, go to IDLE. Otherwise load inst = pc_q[2] ? r_data[63:32] : r_data[31:0], inst_pc=pc_q, inst_err=(r_resp!=0), inst_valid=1, go to HOLD. r_last=0 is tolerated and treated as the final beat.
- HOLD: inst_valid=1 with outputs stable until inst_ready. On inst_ready: inst_valid=0. If pc_valid & !flush in the same cycle, accept the new request (pc_ready=inst_ready in HOLD) and go to AR. Otherwise go to IDLE. Flush in HOLD clears inst_valid next cycle and goes to IDLE, even if inst_ready is also high.
- pc_ready=1 only in IDLE, or in HOLD when inst_ready=1 and flush=0. At most one outstanding transaction.
- Minimum latency: request accepted at cycle T → ar_valid at T+1. With ar_ready=1 at T+1 and r_valid at T+2, inst_valid is at T+3.
- Flush has priority over all other events in the same cycle.
- On error the instruction word is still forwarded; decode acts on inst_err.

Test Plan:
- Single fetch, pc_addr=0x80000000, ar_ready=1, r_data=0x1111111100000013, resp=0 → ar_addr=0x80000000, len=0, size=3; inst=0x00000013, inst_pc=0x80000000, inst_valid 3 cycles after request.
- Upper-word select: pc_addr=0x80000004, same r_data → ar_addr=0x80000000, inst=0x11111111.
- Backpressure: ar_ready low 5 cycles, then inst_ready low 4 cycles → ar_addr stable and ar_valid high throughout; inst/inst_pc stable; pc_ready=0 until the inst_ready cycle.
- Flush in R state before r_valid → beat consumed (r_ready=1), inst_valid never asserts, state returns to IDLE, and the next fetch at 0x80000100 returns correct data.
- Error: r_resp=2'b10 → inst_valid=1, inst_err=1; the next good fetch clears inst_err.
- Back-to-back: inst_ready=1 and pc_valid=1 in HOLD → new AR issued next cycle with no IDLE bubble; synchronous reset asserted in AR → ar_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/ysyx_22041071_ifu_fetch.sv
// Instruction-fetch bus stage: takes one PC per handshake, issues a single-beat
// AXI read, and hands {pc, inst, err} to decode through a valid/ready register.
module ysyx_22041071_ifu_fetch #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 8,
  parameter int ID_W     = 4,
  parameter int FETCH_ID = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [ID_W-1:0]   ar_id,
  output logic [LEN_W-1:0]  ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       inst,
  output logic              inst_err,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and its payload never changes until then.
  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic              drop;
  logic              accept;
  logic              beat_keep;
  logic              unused_r_last;

  assign pc_ready  = (state == S_IDLE) | ((state == S_HOLD) & inst_ready & ~flush);
  assign accept    = pc_valid & pc_ready & ~flush;
  assign r_ready   = (state == S_R);
  assign beat_keep = (state == S_R) & r_valid & ~(drop | flush);

  assign ar_id    = ID_W'(FETCH_ID);
  assign ar_len   = '0;
  assign ar_size  = 3'b011;
  assign ar_burst = 2'b01;

  assign fsm_state     = state;
  // Every R beat is treated as the final one, so r_last carries no information.
  assign unused_r_last = r_last;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_AR;
      S_AR:   if (ar_ready) state_nxt = S_R;
      S_R:    if (r_valid) state_nxt = (drop | flush) ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (flush)           state_nxt = S_IDLE;
        else if (inst_ready) state_nxt = accept ? S_AR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      ar_valid   <= 1'b0;
      ar_addr    <= '0;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        pc_q     <= pc_addr;
        ar_addr  <= {pc_addr[ADDR_W-1:3], 3'b000};
        ar_valid <= 1'b1;
      end else if ((state == S_AR) && ar_ready) begin
        ar_valid <= 1'b0;
      end

      // A redirect while the read is in flight marks its beat for discard.
      if ((state == S_R) && r_valid)
        drop <= 1'b0;
      else if (((state == S_AR) || (state == S_R)) && flush)
        drop <= 1'b1;

      if (beat_keep) begin
        inst       <= pc_q[2] ? r_data[63:32] : r_data[31:0];
        inst_pc    <= pc_q;
        inst_err   <= (r_resp != 2'b00);
        inst_valid <= 1'b1;
      end else if ((state == S_HOLD) && (flush || inst_ready)) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_ifu_fetch.sv
// Bench for the fetch stage: a randomised AXI read slave plus a transaction-level
// scoreboard of expected {pc, inst, err} results, with directed scenarios first.
module tb_ysyx_22041071_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_valid, pc_ready, flush;
  logic [63:0] pc_addr;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        inst_valid, inst_ready, inst_err;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  ysyx_22041071_ifu_fetch dut (
    .clk(clk), .reset(reset),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_addr(pc_addr), .flush(flush),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst(inst),
    .inst_err(inst_err), .fsm_state(fsm_state)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int ar_prob = 100;
  int r_prob = 100;
  logic        fix_en = 1'b0;
  logic [63:0] fix_data = '0;
  logic [1:0]  fix_resp = '0;

  logic [96:0] exp_q[$];
  logic [63:0] exp_ar_q[$];
  logic [63:0] rq[$];
  bit txn_open = 0;
  bit beat_done = 0;
  bit kill = 0;
  bit outstanding, exp_ready;
  event sampled;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Memory image: 8-byte words derived from the word address, or a fixed word.
  function automatic logic [63:0] mem_data(input logic [63:0] a);
    logic [63:0] w;
    w = {a[63:3], 3'b000};
    return fix_en ? fix_data : {w[31:0] ^ 32'hdeadbeef, w[31:0] + 32'h13};
  endfunction

  function automatic logic [1:0] mem_resp(input logic [63:0] a);
    return fix_en ? fix_resp : ((a[6:3] == 4'hf) ? 2'b10 : 2'b00);
  endfunction

  function automatic logic [96:0] model_fetch(input logic [63:0] a);
    logic [63:0] d;
    d = mem_data(a);
    return {a, (a[2] ? d[63:32] : d[31:0]), (mem_resp(a) != 2'b00)};
  endfunction

  // AXI read slave: drives at the falling edge.
  initial begin
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0; r_last = 0;
  end

  always @(negedge clk) begin
    if (kill || beat_done) begin
      r_valid = 0; kill = 0; beat_done = 0;
    end
    ar_ready = ($urandom_range(99) < ar_prob);
    if (!r_valid && rq.size() > 0 && $urandom_range(99) < r_prob) begin
      r_valid = 1;
      r_data  = mem_data(rq[0]);
      r_resp  = mem_resp(rq[0]);
      r_last  = $urandom_range(1);
    end
  end

  // Monitor / scoreboard: samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (reset) begin
      exp_q.delete(); exp_ar_q.delete(); rq.delete();
      txn_open = 0; beat_done = 0; kill = 1;
    end else begin
      outstanding = txn_open || (exp_q.size() > 0);
      exp_ready = !outstanding || (!txn_open && inst_ready && !flush);
      check("pc_ready", pc_ready, exp_ready);
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL inst_unexpected: got inst_valid=1 pc=0x%0h, required no pending fetch", inst_pc);
        end else begin
          check("inst_result", {inst_pc, inst, inst_err}, exp_q[0]);
          if (inst_ready && !flush) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      if (ar_valid && ar_ready) begin
        if (exp_ar_q.size() == 0) begin
          checks++;
          $display("FAIL ar_unexpected: got ar_addr=0x%0h, required no AR", ar_addr);
        end else begin
          check("ar_addr", ar_addr, exp_ar_q.pop_front());
        end
        check("ar_attr", {ar_id, ar_len, ar_size, ar_burst}, {4'd0, 8'd0, 3'b011, 2'b01});
        rq.push_back(ar_addr);
      end
      if (r_valid && r_ready) begin
        void'(rq.pop_front());
        beat_done = 1;
        txn_open = 0;
      end
      if (pc_valid && pc_ready && !flush) begin
        exp_q.push_back(model_fetch(pc_addr));
        exp_ar_q.push_back({pc_addr[63:3], 3'b000});
        txn_open = 1;
      end
    end
    -> sampled;
  end

  task automatic issue(input logic [63:0] a);
    int n = 0;
    @(negedge clk); pc_valid = 1; pc_addr = a; #1;
    while (!pc_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!pc_ready) begin
      checks++;
      $display("FAIL issue_timeout: got pc_ready=0, required 1 within 50 cycles");
    end
    accept_cyc = cyc + 1;
    @(negedge clk); pc_valid = 0;
  endtask

  task automatic wait_inst(output int lat);
    int n = 0;
    lat = -1;
    while (n < 100) begin
      @(sampled);
      if (inst_valid) begin lat = cyc - accept_cyc; break; end
      n++;
    end
    if (lat < 0) begin
      checks++;
      $display("FAIL inst_timeout: got inst_valid=0, required 1 within 100 cycles");
    end
  endtask

  task automatic consume();
    @(negedge clk); inst_ready = 1;
    @(negedge clk); inst_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    reset = 1; pc_valid = 0; pc_addr = '0; flush = 0; inst_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {ar_valid, r_ready, inst_valid, inst_err, inst, inst_pc, ar_addr},
          {4'b0000, 32'h0, 64'h0, 64'h0});
    @(negedge clk); reset = 0; #1;
    check("rst_pc_ready", pc_ready, 1'b1);

    // Single fetch, lower word, minimum latency.
    fix_en = 1; fix_data = 64'h1111111100000013; fix_resp = 2'b00;
    issue(64'h80000000); #1;
    check("t1_ar", {ar_valid, ar_addr, ar_len, ar_size}, {1'b1, 64'h80000000, 8'd0, 3'b011});
    wait_inst(lat);
    check("t1_latency", lat, 3);
    check("t1_inst", {inst_pc, inst, inst_err}, {64'h80000000, 32'h00000013, 1'b0});
    consume();

    // Upper-word select.
    issue(64'h80000004); #1;
    check("t2_ar_addr", ar_addr, 64'h80000000);
    wait_inst(lat);
    check("t2_inst", {inst_pc, inst}, {64'h80000004, 32'h11111111});
    consume();

    // Backpressure on AR then on decode.
    ar_prob = 0;
    issue(64'h80000010);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_ar_hold", {ar_valid, ar_addr, pc_ready}, {1'b1, 64'h80000010, 1'b0});
      @(negedge clk);
    end
    ar_prob = 100;
    wait_inst(lat);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t3_inst_hold", {inst_valid, inst_pc, inst, pc_ready},
            {1'b1, 64'h80000010, 32'h00000013, 1'b0});
    end
    @(negedge clk); inst_ready = 1; #1;
    check("t3_pc_ready", pc_ready, 1'b1);
    @(negedge clk); inst_ready = 0;

    // Flush while waiting in R.
    fix_en = 0; r_prob = 0;
    issue(64'h80000020);
    @(negedge clk); #1;
    check("t4_r_ready", r_ready, 1'b1);
    flush = 1;
    @(negedge clk); flush = 0; r_prob = 100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("t4_no_inst", inst_valid, 1'b0);
    end
    check("t4_idle", {r_valid, pc_ready}, 2'b01);
    issue(64'h80000100);
    wait_inst(lat);
    check("t4_refetch", {inst_pc, inst, inst_err}, model_fetch(64'h80000100));
    consume();

    // Bus error, then a clean fetch.
    fix_en = 1; fix_data = 64'hcafebabe00100073; fix_resp = 2'b10;
    issue(64'h80000034);
    wait_inst(lat);
    check("t5_err", {inst_valid, inst_err, inst}, {1'b1, 1'b1, 32'hcafebabe});
    consume();
    fix_resp = 2'b00;
    issue(64'h80000038);
    wait_inst(lat);
    check("t5_err_clear", {inst_err, inst}, {1'b0, 32'h00100073});

    // Back-to-back: new request accepted in the decode handshake cycle.
    @(negedge clk); inst_ready = 1; pc_valid = 1; pc_addr = 64'h80000044; #1;
    check("t6_pc_ready", pc_ready, 1'b1);
    @(negedge clk); pc_valid = 0; inst_ready = 0; #1;
    accept_cyc = cyc;
    check("t6_ar_next", {ar_valid, ar_addr}, {1'b1, 64'h80000040});
    wait_inst(lat);
    check("t6_latency", lat, 3);
    consume();

    // Synchronous reset while the AR is pending.
    ar_prob = 0;
    issue(64'h80000080);
    reset = 1; #1;
    check("t7_ar_before", ar_valid, 1'b1);
    @(negedge clk); reset = 0; #1;
    check("t7_ar_after", {ar_valid, pc_ready, inst_valid}, 3'b010);
    ar_prob = 100; fix_en = 0;

    // Randomised traffic.
    ar_prob = 60; r_prob = 60;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      pc_valid   = $urandom_range(1);
      pc_addr    = 64'h80000000 + 64'($urandom_range(255)) * 4;
      flush      = ($urandom_range(19) == 0);
      inst_ready = ($urandom_range(9) < 7);
    end
    @(negedge clk); pc_valid = 0; flush = 0; inst_ready = 1; ar_prob = 100; r_prob = 100;
    n = 0;
    while (n < 200) begin
      @(sampled);
      if (exp_q.size() == 0 && !txn_open) break;
      n++;
    end
    check("drain_empty", {txn_open, 32'(exp_q.size())}, 33'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
